roll_uart_reporter: RTL and testbench

Downstream consumer of the dice-roll post-processing stage. Accepts each validated roll (die select + 5-bit result) on a one-cycle strobe, buffers it in a small FIFO, and transmits it as a fixed 6-byte ASCII line over an 8N1 UART so that results can be logged without the NIOS. Sits beside the custom-instruction path, fed from the same `o_dieRoll` / valid strobe.

---
 rtl/dice_pkg.sv | 33 +++
 rtl/roll_fifo.sv | 64 ++++++
 rtl/roll_uart_reporter.sv | 203 ++++++++++++++++++++
 tb/tb_roll_uart_reporter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// dice_pkg: shared constants and types for the dice-roll UART reporter.
//   - ASCII codes used to build the 6-byte "S:TO\r\n" result line
//   - MSG_LEN: bytes per result line
//   - uart_state_e: 2-bit UART transmitter state encoding
//   - hex_ascii(): 4-bit value to uppercase ASCII hex digit
package dice_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int MSG_LEN = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] n8;
        n8 = {4'd0, nib};
        if (nib < 4'd10) begin
            hex_ascii = ASCII_0 + n8;
        end else begin
            hex_ascii = ASCII_A + n8 - 8'd10;
        end
    endfunction

endpackage

// File: rtl/roll_fifo.sv
// roll_fifo: synchronous FIFO for buffered dice rolls.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write wr_data this cycle (caller guarantees room or a
//                simultaneous pop)
//   pop        : drop the head entry this cycle (caller guarantees non-empty)
//   rd_data    : head entry, valid whenever empty is low
//   count      : number of stored entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
module roll_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid. When full,
    // a push+pop pair writes the slot being read; the read sees the old
    // value because the write only lands at the clock edge.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/roll_uart_reporter.sv
// roll_uart_reporter: buffers validated dice rolls and sends each one as a
// 6-byte ASCII line ("<hex sel>:<tens><ones>\r\n") over an 8N1 UART.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_valid          : one-cycle strobe, roll present on i_dieSelect/i_dieRoll
//   i_dieSelect      : die select code 0..15
//   i_dieRoll        : roll value 0..31
//   i_clrOvf         : one-cycle pulse clearing o_overflow (a new drop wins)
//   o_tx             : UART serial output, idle high
//   o_busy           : a line is being sent or rolls are still buffered
//   o_overflow       : sticky, a roll was dropped on a full FIFO
//   o_fifoCount      : number of buffered rolls
module roll_uart_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [3:0]                    i_dieSelect,
    input  logic [4:0]                    i_dieRoll,
    input  logic                          i_clrOvf,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

    import dice_pkg::*;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BYTE_LAST = 3'(MSG_LEN - 1);

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [8:0]       fifo_rd;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Transmitter state
    uart_state_e      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [3:0]       sel_q, sel_d;
    logic [4:0]       roll_q, roll_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       tx_byte;
    logic [1:0]       tens;
    logic [4:0]       ones;
    logic             baud_done;

    roll_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({i_dieSelect, i_dieRoll}),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO still takes a roll when the transmitter pops that cycle.
    assign fifo_push = i_valid && (!fifo_full || fifo_pop);
    assign baud_done = (baud_q == BAUD_LAST);

    // Next-state logic for the transmitter
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sel_d    = sel_q;
        roll_d   = roll_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sel_d    = fifo_rd[8:5];
                    roll_d   = fifo_rd[4:0];
                    byte_d   = 3'd0;
                    bit_d    = 3'd0;
                    baud_d   = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q < BYTE_LAST) begin
                        // Back-to-back bytes: no idle gap inside a line.
                        byte_d  = byte_q + 3'd1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte mux and decimal split. Driven from the *_d values so that o_tx is
    // a flop whose value lines up with the state being entered.
    always_comb begin
        if (roll_d >= 5'd30)      tens = 2'd3;
        else if (roll_d >= 5'd20) tens = 2'd2;
        else if (roll_d >= 5'd10) tens = 2'd1;
        else                      tens = 2'd0;
        ones = roll_d - ({3'd0, tens} * 5'd10);

        case (byte_d)
            3'd0:    tx_byte = hex_ascii(sel_d);
            3'd1:    tx_byte = ASCII_COLON;
            3'd2:    tx_byte = ASCII_0 + {6'd0, tens};
            3'd3:    tx_byte = ASCII_0 + {3'd0, ones};
            3'd4:    tx_byte = ASCII_CR;
            default: tx_byte = ASCII_LF;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_byte[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // Busy looks one cycle ahead: no pop happens outside IDLE, and an IDLE pop
    // always moves to START, so the FIFO term only needs the current count
    // plus any push.
    always_comb begin
        busy_d = (state_d != ST_IDLE) || fifo_push || (fifo_count != '0);
        if (i_valid && !fifo_push) ovf_d = 1'b1;
        else if (i_clrOvf)         ovf_d = 1'b0;
        else                       ovf_d = ovf_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            sel_q   <= 4'd0;
            roll_q  <= 5'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sel_q   <= sel_d;
            roll_q  <= roll_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_tx        = tx_q;
    assign o_busy      = busy_q;
    assign o_overflow  = ovf_q;
    assign o_fifoCount = fifo_count;

endmodule

// File: tb/tb_roll_uart_reporter.sv
// Bench for roll_uart_reporter with CLKS_PER_BIT = 4. Expected bytes are
// queued when a roll is accepted; a UART receiver process decodes o_tx and
// checks against the queue. A timeline model (push cycle, pop cycle per roll)
// predicts acceptance, o_fifoCount, o_busy and o_overflow each cycle.
module tb_roll_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 60 * CPB;   // cycles of one 6-byte line

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [4:0] roll = 5'd0;
    logic       tx, busy, ovf;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    roll_uart_reporter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (valid),
        .i_dieSelect (sel),
        .i_dieRoll   (roll),
        .i_clrOvf    (clr),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_overflow  (ovf),
        .o_fifoCount (cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int push_t; int pop_t; } ent_t;
    ent_t       ents[$];
    int         last_pop = -100000;
    bit         ovf_exp = 1'b0;
    logic [7:0] exp_q[$];

    // One clock cycle: check outputs against the model, then drive inputs.
    task automatic step(input bit v, input logic [3:0] s, input logic [4:0] r, input bit c);
        int t;
        int n;
        bit pn;
        bit be;
        bit acc;
        int p;
        int si;
        int ri;
        t = cyc; n = 0; pn = 0; be = 0;
        while (ents.size() > 0 && ents[0].pop_t + FRAME < t) void'(ents.pop_front());
        foreach (ents[i]) begin
            if (ents[i].pop_t >= t) n++;
            if (ents[i].pop_t == t) pn = 1;
            if (t <= ents[i].pop_t + FRAME) be = 1;
        end
        chk("fifo_count", 32'(cnt), n);
        chk("busy", 32'(busy), 32'(be));
        chk("overflow", 32'(ovf), 32'(ovf_exp));
        acc = v && (n < DEPTH || pn);
        if (acc) begin
            p = (t + 1 > last_pop + FRAME + 1) ? t + 1 : last_pop + FRAME + 1;
            last_pop = p;
            ents.push_back('{t, p});
            si = int'(s);
            ri = int'(r);
            exp_q.push_back(8'((si < 10) ? 48 + si : 65 + si - 10));
            exp_q.push_back(8'h3A);
            exp_q.push_back(8'(48 + ri / 10));
            exp_q.push_back(8'(48 + ri % 10));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        if (v && !acc) ovf_exp = 1'b1;
        else if (c)    ovf_exp = 1'b0;
        valid = v; sel = s; roll = r; clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 5'd0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ents.size() > 0 || exp_q.size() > 0) && k < 3000) begin
            idle(1);
            k++;
        end
        chk("drain_in_time", 32'(k < 3000), 32'd1);
    endtask

    // ---------------- UART receiver / scoreboard ----------------
    bit         mon_act = 1'b0;
    int         mon_off = 0;
    logic [7:0] mon_byte = 8'd0;
    bit         fall_seen = 1'b1;
    int         fall_cyc = 0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_off = 0;
                if (!fall_seen) begin
                    fall_seen = 1'b1;
                    fall_cyc  = cyc;
                end
            end
        end else begin
            mon_off++;
            if (mon_off >= CPB + CPB / 2 && mon_off < 9 * CPB && (mon_off - CPB / 2) % CPB == 0) begin
                mon_byte[(mon_off - CPB / 2) / CPB - 1] = tx;
            end else if (mon_off == 9 * CPB + CPB / 2) begin
                chk("stop_bit", 32'(tx), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_frame @cyc %0d: got byte %02h, expected none", cyc, mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("tx_byte", 32'(mon_byte), 32'(mon_exp));
                end
                mon_act = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog @cyc %0d: got no finish, expected finish", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(cnt), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Single roll: latency of o_tx and o_busy
        fall_seen = 1'b0;
        n0 = cyc;
        step(1'b1, 4'd5, 5'd17, 1'b0);
        while (cyc < n0 + 241) idle(1);
        chk("fall_seen", 32'(fall_seen), 32'd1);
        chk("tx_fall_cycle", fall_cyc, n0 + 2);
        chk("busy_before_end", 32'(busy), 32'd1);
        idle(1);
        chk("busy_drop_cycle", 32'(busy), 32'd0);
        drain();

        // Hex letter, zero roll, max roll
        step(1'b1, 4'hA, 5'd0, 1'b0);
        step(1'b1, 4'hF, 5'd31, 1'b0);
        drain();

        // Burst of six: sixth dropped; clear collisions; push on full+pop
        n0 = cyc;
        repeat (6) step(1'b1, 4'($urandom), 5'($urandom_range(0, 31)), 1'b0);
        chk("burst_count", 32'(cnt), 32'd4);
        chk("burst_ovf", 32'(ovf), 32'd1);
        while (cyc < n0 + 10) idle(1);
        step(1'b1, 4'($urandom), 5'($urandom_range(0, 31)), 1'b1);
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        step(1'b0, 4'd0, 5'd0, 1'b1);
        chk("ovf_cleared", 32'(ovf), 32'd0);
        while (cyc < n0 + 242) idle(1);
        chk("full_before_pop", 32'(cnt), 32'd4);
        step(1'b1, 4'($urandom), 5'($urandom_range(0, 31)), 1'b0);
        chk("full_push_pop_count", 32'(cnt), 32'd4);
        chk("full_push_pop_ovf", 32'(ovf), 32'd0);
        drain();

        // Asynchronous reset during bit 3 of byte 2
        n0 = cyc;
        step(1'b1, 4'd3, 5'd25, 1'b0);
        step(1'b1, 4'd7, 5'd7, 1'b0);
        while (cyc < n0 + 98) idle(1);
        valid = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_count", 32'(cnt), 32'd0);
        ents.delete();
        exp_q.delete();
        ovf_exp = 1'b0;
        last_pop = -100000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, 4'd2, 5'd9, 1'b0);
        drain();

        // Randomized traffic with bursts and clears
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
            else                           idle($urandom_range(20, 260));
            if ($urandom_range(0, 9) == 0) step(1'b0, 4'd0, 5'd0, 1'b1);
            step(1'b1, 4'($urandom), 5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
